// File: rtl/spec_hist_pkg.sv
// Shared constants for the pulse-height histogrammer: FSM encoding, default geometry
// and the drop counter ceiling.
package spec_hist_pkg;

    localparam int DWIDTH_DEF = 16;
    localparam int AWIDTH_DEF = 9;
    localparam int WORDS_DEF  = 512;
    localparam int CHW_DEF    = 12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_CLR  = 2'd3;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/spec_histogrammer.sv
// Builds a pulse-height spectrum in an external dual-port RAM (port 1): one saturating
// read-modify-write per accepted event, plus a full-RAM zero sweep on clear.
module spec_histogrammer
    import spec_hist_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int WORDS  = WORDS_DEF,
    parameter int CHW    = CHW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acq_en,
    input  logic              ev_stb,
    input  logic [CHW-1:0]    ev_adc,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_busy,
    output logic              mem_load,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_d,
    input  logic [DWIDTH-1:0] mem_q,
    output logic [31:0]       ev_count,
    output logic [15:0]       drop_count,
    output logic              sat_flag
);

    logic [1:0]        state_q, state_d;
    logic [AWIDTH-1:0] bin_q, bin_d;
    logic [AWIDTH-1:0] clr_addr_q, clr_addr_d;
    logic              clr_pend_q, clr_pend_d;
    logic [31:0]       ev_cnt_q, ev_cnt_d;
    logic [15:0]       drop_q, drop_d;
    logic              sat_q, sat_d;

    logic              ev_valid;
    logic              accept;
    logic              clr_go;
    logic              q_full;
    logic [AWIDTH-1:0] bin_sel;
    logic              unused_adc;

    assign ev_valid   = ev_stb && acq_en;
    assign q_full     = (mem_q == {DWIDTH{1'b1}});
    // Bins use the most significant ADC bits; the rest only feed a parity sink.
    assign bin_sel    = ev_adc[CHW-1 -: AWIDTH];
    assign unused_adc = ^ev_adc;

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        clr_addr_d = clr_addr_q;
        clr_pend_d = clr_pend_q;
        ev_cnt_d   = ev_cnt_q;
        drop_d     = drop_q;
        sat_d      = sat_q;
        accept     = 1'b0;
        clr_go     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clr_req || clr_pend_q) begin
                    clr_go     = 1'b1;
                    clr_pend_d = 1'b0;
                    clr_addr_d = '0;
                    state_d    = ST_CLR;
                end else if (ev_valid) begin
                    accept  = 1'b1;
                    bin_d   = bin_sel;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (clr_req) clr_pend_d = 1'b1;
                state_d = ST_WR;
            end
            ST_WR: begin
                if (clr_req) clr_pend_d = 1'b1;
                if (q_full) sat_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_CLR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == AWIDTH'(WORDS - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A clear wipes the statistics, including any strobe lost in the same cycle.
        if (clr_go) begin
            ev_cnt_d = '0;
            drop_d   = '0;
            sat_d    = 1'b0;
        end else begin
            if (accept) ev_cnt_d = ev_cnt_q + 32'd1;
            if (ev_valid && !accept && drop_q != DROP_MAX) drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            clr_addr_q <= '0;
            clr_pend_q <= 1'b0;
            ev_cnt_q   <= '0;
            drop_q     <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            clr_addr_q <= clr_addr_d;
            clr_pend_q <= clr_pend_d;
            ev_cnt_q   <= ev_cnt_d;
            drop_q     <= drop_d;
            sat_q      <= sat_d;
        end
    end

    // RAM port is decoded from registered state only, so reset drops mem_load at once.
    always_comb begin
        mem_load = 1'b0;
        mem_addr = '0;
        mem_d    = '0;
        case (state_q)
            ST_RD: mem_addr = bin_q;
            ST_WR: begin
                mem_load = 1'b1;
                mem_addr = bin_q;
                mem_d    = q_full ? mem_q : mem_q + 1'b1;
            end
            ST_CLR: begin
                mem_load = 1'b1;
                mem_addr = clr_addr_q;
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign clr_busy   = (state_q == ST_CLR);
    assign ev_count   = ev_cnt_q;
    assign drop_count = drop_q;
    assign sat_flag   = sat_q;

endmodule
